vmicro16_apb_arbiter: RTL
=========================

VMICRO16_APB_ARBITER -- requirements
Module: vmicro16_apb_arbiter

Interface
REQ-001 The block SHALL have parameter MASTERS, default 2, number of requesting APB masters (cores), legal range 1..8.
REQ-002 The block SHALL have parameter APB_WIDTH, default 16, width of address and data buses.
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-005 The block SHALL have port S_PADDR  input  MASTERS*APB_WIDTH  per-master address, master i in bits [APB_WIDTH*i +: APB_WIDTH].
REQ-006 The block SHALL have port S_PWRITE  input  MASTERS  per-master write strobe (1 = write).
REQ-007 The block SHALL have port S_PSELx  input  MASTERS  per-master select; high = transfer request.
REQ-008 The block SHALL have port S_PENABLE  input  MASTERS  per-master enable; ignored for arbitration.
REQ-009 The block SHALL have port S_PWDATA  input  MASTERS*APB_WIDTH  per-master write data, same packing as S_PADDR.
REQ-010 The block SHALL have port S_PRDATA  output  MASTERS*APB_WIDTH  per-master read data, same packing.
REQ-011 The block SHALL have port S_PREADY  output  MASTERS  per-master transfer-complete pulse.
REQ-012 The block SHALL have port M_PADDR  output  APB_WIDTH  address to the shared APB interconnect.
REQ-013 The block SHALL have port M_PWRITE  output  1  write strobe to the interconnect.
REQ-014 The block SHALL have port M_PSELx  output  1  select to the interconnect.
REQ-015 The block SHALL have port M_PENABLE  output  1  enable to the interconnect.
REQ-016 The block SHALL have port M_PWDATA  output  APB_WIDTH  write data to the interconnect.
REQ-017 The block SHALL have port M_PRDATA  input  APB_WIDTH  read data from the interconnect.
REQ-018 The block SHALL have port M_PREADY  input  1  completion from the interconnect.

Function
REQ-019 The block SHALL implement an FSM with states IDLE, SETUP and ACCESS, plus a registered grant index gnt and a round-robin pointer rr, each ceil(log2(MASTERS)) bits wide with a minimum of 1 bit.
REQ-020 In IDLE with any S_PSELx bit high, the block SHALL pick as winner the first requesting index found searching upward from rr with wrap-around, load gnt with the winner, and move to SETUP on the next edge.
REQ-021 In IDLE with S_PSELx all zero, the block SHALL stay in IDLE, leaving gnt and rr unchanged.
REQ-022 SETUP SHALL last exactly one cycle (M_PSELx=1, M_PENABLE=0), then move to ACCESS.
REQ-023 In ACCESS the block SHALL drive M_PSELx=1 and M_PENABLE=1, and hold ACCESS while M_PREADY=0 (unbounded wait states).
REQ-024 In ACCESS with M_PREADY=1, the block SHALL set S_PREADY[gnt]=1 combinationally in that cycle, set rr to (gnt+1) mod MASTERS, and return to IDLE.
REQ-025 The minimum request-to-completion latency SHALL be 3 cycles (IDLE sample, SETUP, ACCESS), plus one cycle per slave wait state.
REQ-026 Back-to-back transfers SHALL pass through IDLE for one cycle, so M_PSELx is low for at least one cycle between grants.
REQ-027 In SETUP and ACCESS, the block SHALL drive M_PADDR, M_PWRITE and M_PWDATA combinationally from master gnt; in IDLE it SHALL drive them as 0.
REQ-028 S_PRDATA slot gnt SHALL equal M_PRDATA in ACCESS; all other slots, and all slots outside ACCESS, SHALL be 0.
REQ-029 S_PREADY SHALL be 0 for every non-granted master and in every state other than ACCESS with M_PREADY=1.
REQ-030 Once gnt is loaded, the grant SHALL be held until completion, even if S_PSELx[gnt] drops early (protocol violation is tolerated; no abort).
REQ-031 Requests from non-granted masters SHALL have no effect on M_* outputs until the arbiter next samples in IDLE.
REQ-032 With MASTERS=1, the block SHALL behave as a pass-through with the same SETUP/ACCESS sequencing; rr SHALL stay 0.

Reset
REQ-033 While reset=0, the block SHALL asynchronously force state=IDLE, gnt=0 and rr=0.
REQ-034 While reset=0, the block SHALL drive M_PSELx=0, M_PENABLE=0, M_PADDR=0, M_PWRITE=0, M_PWDATA=0, S_PREADY=0 and S_PRDATA=0, including when reset is asserted mid-ACCESS; no completion pulse SHALL be issued for a transfer cut off by reset.
REQ-035 After reset deasserts, the first arbitration SHALL occur on the first rising edge with reset=1.

Verification (MASTERS=2, APB_WIDTH=16)
REQ-036 Reset check: reset=0 at any state -> all outputs 0 immediately, without a clock edge; first post-reset grant goes to master 0 if both masters request.
REQ-037 Single write: master 0 requests PADDR=0x0010, PWDATA=0xABCD, PWRITE=1, slave M_PREADY=1 -> M_PSELx high cycles 2-3, M_PENABLE high cycle 3, M_PADDR=0x0010, M_PWDATA=0xABCD, S_PREADY=2'b01 in cycle 3 only.
REQ-038 Fairness: both masters hold requests continuously -> grants alternate 0,1,0,1; each completion is followed by one IDLE cycle.
REQ-039 Wait states: M_PREADY low for 4 ACCESS cycles -> ACCESS lasts 5 cycles, M_PADDR stable throughout, S_PREADY=0 until the 5th cycle.
REQ-040 Read routing: master 1 reads, M_PRDATA=0x1234 -> S_PRDATA[31:16]=0x1234, S_PRDATA[15:0]=0x0000, S_PREADY=2'b10.
REQ-041 Mid-transfer reset: reset=0 during ACCESS with M_PREADY=0 -> M_PSELx and M_PENABLE drop immediately, S_PREADY stays 0, and rr returns to 0.

Source files
------------

// File: rtl/vmicro16_apb_arbiter.sv
// Round-robin arbiter that funnels several APB masters onto one shared APB
// interconnect, running one IDLE/SETUP/ACCESS transfer at a time.
module vmicro16_apb_arbiter #(
  parameter int MASTERS   = 2,
  parameter int APB_WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,

  input  logic [MASTERS*APB_WIDTH-1:0] S_PADDR,
  input  logic [MASTERS-1:0]           S_PWRITE,
  input  logic [MASTERS-1:0]           S_PSELx,
  input  logic [MASTERS-1:0]           S_PENABLE,
  input  logic [MASTERS*APB_WIDTH-1:0] S_PWDATA,
  output logic [MASTERS*APB_WIDTH-1:0] S_PRDATA,
  output logic [MASTERS-1:0]           S_PREADY,

  output logic [APB_WIDTH-1:0]         M_PADDR,
  output logic                         M_PWRITE,
  output logic                         M_PSELx,
  output logic                         M_PENABLE,
  output logic [APB_WIDTH-1:0]         M_PWDATA,
  input  logic [APB_WIDTH-1:0]         M_PRDATA,
  input  logic                         M_PREADY
);

  localparam int GW = (MASTERS > 1) ? $clog2(MASTERS) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t        state, state_nxt;
  logic [GW-1:0] gnt, gnt_nxt;
  logic [GW-1:0] rr, rr_nxt;
  logic [GW-1:0] winner;

  // Masters drive PENABLE for their own protocol; arbitration never looks at it.
  logic unused_penable;
  assign unused_penable = ^S_PENABLE;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others; blocking here would chain them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      gnt   <= '0;
      rr    <= '0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      rr    <= rr_nxt;
    end
  end

  // Descending scan so the requester closest above rr is the last to overwrite.
  always_comb begin
    winner = '0;
    for (int k = MASTERS - 1; k >= 0; k--) begin
      if (S_PSELx[(int'(rr) + k) % MASTERS])
        winner = GW'((int'(rr) + k) % MASTERS);
    end
  end

  // NOTE: every signal written in a combinational block gets a default first,
  // otherwise paths that skip an assignment infer a latch.
  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    rr_nxt    = rr;
    unique case (state)
      IDLE: begin
        if (|S_PSELx) begin
          state_nxt = SETUP;
          gnt_nxt   = winner;
        end
      end
      SETUP:  state_nxt = ACCESS;
      ACCESS: begin
        if (M_PREADY) begin
          state_nxt = IDLE;
          rr_nxt    = (int'(gnt) == MASTERS - 1) ? '0 : gnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Reset forces state to IDLE asynchronously, which zeroes every output below.
  always_comb begin
    M_PSELx   = 1'b0;
    M_PENABLE = 1'b0;
    M_PADDR   = '0;
    M_PWRITE  = 1'b0;
    M_PWDATA  = '0;
    S_PRDATA  = '0;
    S_PREADY  = '0;
    if (state != IDLE) begin
      M_PSELx  = 1'b1;
      M_PADDR  = S_PADDR[APB_WIDTH*int'(gnt) +: APB_WIDTH];
      M_PWDATA = S_PWDATA[APB_WIDTH*int'(gnt) +: APB_WIDTH];
      M_PWRITE = S_PWRITE[gnt];
    end
    if (state == ACCESS) begin
      M_PENABLE = 1'b1;
      S_PRDATA[APB_WIDTH*int'(gnt) +: APB_WIDTH] = M_PRDATA;
      S_PREADY[gnt] = M_PREADY;
    end
  end

endmodule
